// File: rtl/flt_result_checker.sv
// Response checker for the single-precision less-than (flt) unit: recomputes the
// golden result over a two-stage pipeline and tallies pass/fail/skip per vector.
module flt_result_checker #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_c,
  input  logic             in_last,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             first_fail_valid,
  output logic [31:0]      first_fail_a,
  output logic [31:0]      first_fail_b,
  output logic [31:0]      first_fail_c,
  output logic             done
);
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             accept;

  logic             s0_valid_q, s0_last_q;
  logic [DW-1:0]    s0_a_q, s0_b_q, s0_c_q;
  logic             s1_valid_q, s1_last_q, s1_nan_q, s1_az_q, s1_bz_q;
  logic [DW-1:0]    s1_a_q, s1_b_q, s1_c_q;

  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
  logic             ff_valid_q, ff_valid_d;
  logic [DW-1:0]    ff_a_q, ff_a_d, ff_b_q, ff_b_d, ff_c_q, ff_c_d;

  logic [DW-1:0]    fa, fb, expected;
  logic             lt;

  function automatic logic is_nan(input logic [DW-1:0] x);
    return (x[DW-2 -: EW] == '1) && (x[MW-1:0] != '0);
  endfunction

  function automatic logic is_zero(input logic [DW-1:0] x);
    return x[DW-2 -: EW] == '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  // Ready is registered from the next state so it never follows in_valid.
  assign accept = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (s1_valid_q && s1_last_q) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
    if (clear) state_d = RUN;
    ready_d = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Stage 0 captures the transfer; stage 1 classifies the operands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
      s0_c_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_az_q    <= 1'b0;
      s1_bz_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
    end else begin
      s0_valid_q <= accept & ~clear;
      s1_valid_q <= s0_valid_q & ~clear;
      if (accept) begin
        s0_a_q    <= in_a;
        s0_b_q    <= in_b;
        s0_c_q    <= in_c;
        s0_last_q <= in_last;
      end
      if (s0_valid_q) begin
        s1_a_q    <= s0_a_q;
        s1_b_q    <= s0_b_q;
        s1_c_q    <= s0_c_q;
        s1_last_q <= s0_last_q;
        s1_nan_q  <= is_nan(s0_a_q) | is_nan(s0_b_q);
        s1_az_q   <= is_zero(s0_a_q);
        s1_bz_q   <= is_zero(s0_b_q);
      end
    end
  end

  // Golden compare on flushed operands; sign-magnitude ordering covers infinities.
  always_comb begin
    fa = s1_az_q ? '0 : s1_a_q;
    fb = s1_bz_q ? '0 : s1_b_q;
    if (fa[DW-1] != fb[DW-1]) lt = fa[DW-1];
    else if (fa[DW-1])        lt = fa[DW-2:0] > fb[DW-2:0];
    else                      lt = fa[DW-2:0] < fb[DW-2:0];
    expected = DW'(lt);
  end

  always_comb begin
    pass_d     = pass_q;
    fail_d     = fail_q;
    skip_d     = skip_q;
    ff_valid_d = ff_valid_q;
    ff_a_d     = ff_a_q;
    ff_b_d     = ff_b_q;
    ff_c_d     = ff_c_q;
    if (s1_valid_q && state_q != DONE) begin
      if (s1_nan_q) begin
        skip_d = sat_inc(skip_q);
      end else if (s1_c_q == expected) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        if (!ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_a_d     = s1_a_q;
          ff_b_d     = s1_b_q;
          ff_c_d     = s1_c_q;
        end
      end
    end
    if (clear) begin
      pass_d     = '0;
      fail_d     = '0;
      skip_d     = '0;
      ff_valid_d = 1'b0;
      ff_a_d     = '0;
      ff_b_d     = '0;
      ff_c_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pass_q     <= '0;
      fail_q     <= '0;
      skip_q     <= '0;
      ff_valid_q <= 1'b0;
      ff_a_q     <= '0;
      ff_b_q     <= '0;
      ff_c_q     <= '0;
    end else begin
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      skip_q     <= skip_d;
      ff_valid_q <= ff_valid_d;
      ff_a_q     <= ff_a_d;
      ff_b_q     <= ff_b_d;
      ff_c_q     <= ff_c_d;
    end
  end

  assign in_ready         = ready_q;
  assign done             = done_q;
  assign pass_cnt         = pass_q;
  assign fail_cnt         = fail_q;
  assign skip_cnt         = skip_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_a     = ff_a_q;
  assign first_fail_b     = ff_b_q;
  assign first_fail_c     = ff_c_q;
endmodule
